// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war referee.
//   tow_state_t : round sequencing states of the referee FSM
//   WIN_*       : encodings driven on the referee's winner output
package tow_pkg;

  typedef enum logic [2:0] {
    SERVE,
    PLAY,
    WIN_L,
    WIN_R,
    OVER
  } tow_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

endpackage

// File: rtl/key_press_conditioner.sv
// Turns one raw, asynchronous player key into a single-cycle press pulse.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   key   : raw key level, asynchronous to clk, active-high
//   pulse : registered, one-cycle-wide pulse per press; high in the cycle
//           after the third clock edge that samples the key high
module key_press_conditioner (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic key_prev;

  // Two-flop synchronizer followed by a registered rising-edge detect.
  // key_prev trails sync_2 by one cycle, so a held key yields one pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      key_prev <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync_1   <= key;
      sync_2   <= sync_1;
      key_prev <= sync_2;
      pulse    <= sync_2 & ~key_prev;
    end
  end

endmodule

// File: rtl/tow_referee.sv
// Game controller for the tug-of-war light row.
// Conditions both player keys into press pulses fanned out to every light
// cell, detects the rope crossing either end, keeps per-player scores,
// restarts each round through the row's synchronous reset and ends the
// match when a player reaches WIN_SCORE.
// Ports:
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   key_l/key_r : raw player keys (asynchronous, active-high)
//   lights      : lightOn outputs of the row, [NUM_LIGHTS-1] leftmost
//   l_pulse     : one-cycle left press to every cell's L input
//   r_pulse     : one-cycle right press to every cell's R input
//   round_reset : synchronous active-high reset to every cell
//   winner      : 00 none, 10 left, 01 right
//   score_l/r   : rounds won by each player
//   match_over  : high once either score equals WIN_SCORE
module tow_referee
  import tow_pkg::*;
#(
  parameter int NUM_LIGHTS  = 9,
  parameter int SCORE_W     = 3,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_l,
  input  logic                  key_r,
  input  logic [NUM_LIGHTS-1:0] lights,
  output logic                  l_pulse,
  output logic                  r_pulse,
  output logic                  round_reset,
  output logic [1:0]            winner,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  match_over
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(WIN_SCORE);

  tow_state_t        state;
  tow_state_t        next_state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic [1:0]        last_winner;
  logic              raw_l_pulse;
  logic              raw_r_pulse;
  logic              win_l_evt;
  logic              win_r_evt;

  // Only the two end cells decide a round; the inner cells are observed
  // by the row itself and are deliberately not used here.
  logic unused_lights;
  assign unused_lights = ^lights[NUM_LIGHTS-2:1];

  key_press_conditioner u_cond_l (
    .clk   (clk),
    .reset (reset),
    .key   (key_l),
    .pulse (raw_l_pulse)
  );

  key_press_conditioner u_cond_r (
    .clk   (clk),
    .reset (reset),
    .key   (key_r),
    .pulse (raw_r_pulse)
  );

  assign hold_done = (hold_cnt == HOLD_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SERVE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and Moore/gating outputs. Pulses reach the row only in
  // PLAY; a simultaneous L and R press is passed through (cells treat it
  // as no move) but can never win.
  always_comb begin
    next_state  = state;
    l_pulse     = 1'b0;
    r_pulse     = 1'b0;
    round_reset = 1'b0;
    win_l_evt   = 1'b0;
    win_r_evt   = 1'b0;
    winner      = WIN_NONE;
    case (state)
      SERVE: begin
        round_reset = 1'b1;
        next_state  = PLAY;
      end
      PLAY: begin
        l_pulse   = raw_l_pulse;
        r_pulse   = raw_r_pulse;
        win_l_evt = raw_l_pulse & ~raw_r_pulse & lights[NUM_LIGHTS-1];
        win_r_evt = raw_r_pulse & ~raw_l_pulse & lights[0];
        if (win_l_evt) begin
          next_state = WIN_L;
        end else if (win_r_evt) begin
          next_state = WIN_R;
        end
      end
      WIN_L: begin
        winner = WIN_LEFT;
        if (hold_done) begin
          next_state = (score_l == SCORE_MAX) ? OVER : SERVE;
        end
      end
      WIN_R: begin
        winner = WIN_RIGHT;
        if (hold_done) begin
          next_state = (score_r == SCORE_MAX) ? OVER : SERVE;
        end
      end
      OVER: begin
        winner = last_winner;
      end
      default: begin
        next_state = SERVE;
      end
    endcase
  end

  // Hold counter runs only while a winner is displayed and rewinds on
  // expiry, so every win is shown for exactly HOLD_CYCLES cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if ((state == WIN_L) || (state == WIN_R)) begin
      hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
    end else begin
      hold_cnt <= '0;
    end
  end

  // Scores change only on the PLAY->WIN edge and saturate at WIN_SCORE.
  // last_winner remembers who took the final round so OVER can keep
  // showing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score_l     <= '0;
      score_r     <= '0;
      last_winner <= WIN_NONE;
    end else begin
      if (win_l_evt) begin
        last_winner <= WIN_LEFT;
        if (score_l != SCORE_MAX) begin
          score_l <= score_l + 1'b1;
        end
      end
      if (win_r_evt) begin
        last_winner <= WIN_RIGHT;
        if (score_r != SCORE_MAX) begin
          score_r <= score_r + 1'b1;
        end
      end
    end
  end

  assign match_over = (score_l == SCORE_MAX) || (score_r == SCORE_MAX);

endmodule

// File: tb/tb_tow_referee.sv
module tb_tow_referee;

  localparam int NL = 9;
  localparam int SW = 3;
  localparam int WS = 7;
  localparam int HC = 4;

  localparam int M_SERVE = 0;
  localparam int M_PLAY  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_OVER  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          key_l;
  logic          key_r;
  logic [NL-1:0] lights;
  logic          l_pulse;
  logic          r_pulse;
  logic          round_reset;
  logic [1:0]    winner;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          match_over;

  tow_referee #(
    .NUM_LIGHTS  (NL),
    .SCORE_W     (SW),
    .WIN_SCORE   (WS),
    .HOLD_CYCLES (HC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_l       (key_l),
    .key_r       (key_r),
    .lights      (lights),
    .l_pulse     (l_pulse),
    .r_pulse     (r_pulse),
    .round_reset (round_reset),
    .winner      (winner),
    .score_l     (score_l),
    .score_r     (score_r),
    .match_over  (match_over)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int npass   = 0;

  // Reference model: game phase, who won last, remaining hold cycles,
  // scores, and the key levels seen at the most recent clock edges
  // (index 0 = newest sample).
  int m_phase;
  int m_hold_left;
  int m_sl;
  int m_sr;
  bit m_left_won;
  bit hist_l[4];
  bit hist_r[4];

  function automatic bit exp_lp();
    return hist_l[2] && !hist_l[3] && (m_phase == M_PLAY);
  endfunction

  function automatic bit exp_rp();
    return hist_r[2] && !hist_r[3] && (m_phase == M_PLAY);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      hist_l[i] = 1'b0;
      hist_r[i] = 1'b0;
    end
    m_phase     = M_SERVE;
    m_hold_left = 0;
    m_sl        = 0;
    m_sr        = 0;
    m_left_won  = 1'b0;
  endtask

  task automatic model_edge();
    bit pl;
    bit pr;
    pl = exp_lp();
    pr = exp_rp();
    case (m_phase)
      M_SERVE: m_phase = M_PLAY;
      M_PLAY: begin
        if (pl && !pr && lights[NL-1]) begin
          m_phase = M_HOLD; m_left_won = 1'b1; m_hold_left = HC;
          m_sl = (m_sl < WS) ? m_sl + 1 : WS;
        end else if (pr && !pl && lights[0]) begin
          m_phase = M_HOLD; m_left_won = 1'b0; m_hold_left = HC;
          m_sr = (m_sr < WS) ? m_sr + 1 : WS;
        end
      end
      M_HOLD: begin
        m_hold_left--;
        if (m_hold_left == 0) begin
          m_phase = (((m_left_won) ? m_sl : m_sr) == WS) ? M_OVER : M_SERVE;
        end
      end
      default: ;
    endcase
    for (int i = 3; i > 0; i--) begin
      hist_l[i] = hist_l[i-1];
      hist_r[i] = hist_r[i-1];
    end
    hist_l[0] = key_l;
    hist_r[0] = key_r;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    int exp_w;
    exp_w = ((m_phase == M_HOLD) || (m_phase == M_OVER)) ? (m_left_won ? 2 : 1) : 0;
    chk({tag, " l_pulse"},     32'(l_pulse),     32'(exp_lp()));
    chk({tag, " r_pulse"},     32'(r_pulse),     32'(exp_rp()));
    chk({tag, " round_reset"}, 32'(round_reset), 32'(m_phase == M_SERVE));
    chk({tag, " winner"},      32'(winner),      32'(exp_w));
    chk({tag, " score_l"},     32'(score_l),     32'(m_sl));
    chk({tag, " score_r"},     32'(score_r),     32'(m_sr));
    chk({tag, " match_over"},  32'(match_over),  32'((m_sl == WS) || (m_sr == WS)));
  endtask

  task automatic applyStimulus(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    checkOutput(tag);
  endtask

  task automatic do_reset(input string tag);
    key_l = 1'b0;
    key_r = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput(tag);
    chk({tag, " rr_async"}, 32'(round_reset), 32'd1);
    repeat (2) begin
      @(posedge clk);
      #1;
      checkOutput(tag);
    end
    reset = 1'b1;
  endtask

  task automatic press_round(input bit left, input string tag);
    lights = left ? 9'h100 : 9'h001;
    if (left) key_l = 1'b1; else key_r = 1'b1;
    repeat (3) applyStimulus(tag);
    key_l = 1'b0;
    key_r = 1'b0;
    repeat (10) applyStimulus(tag);
  endtask

  initial begin
    int cnt;
    int sel;
    reset  = 1'b0;
    key_l  = 1'b0;
    key_r  = 1'b0;
    lights = 9'h010;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    reset = 1'b1;
    #2;
    chk("rr_before_first_edge", 32'(round_reset), 32'd1);
    repeat (3) applyStimulus("serve");

    // Long hold of the left key with the rope centred.
    cnt = 0;
    key_l = 1'b1;
    repeat (10) begin
      applyStimulus("hold_l");
      if (l_pulse) cnt++;
    end
    key_l = 1'b0;
    repeat (4) applyStimulus("hold_l_idle");
    chk("hold_l pulse_count", 32'(cnt), 32'd1);

    // Simultaneous presses with the rope at the left end: no win.
    cnt = 0;
    lights = 9'h100;
    key_l = 1'b1;
    key_r = 1'b1;
    repeat (5) begin
      applyStimulus("both");
      if (l_pulse && r_pulse) cnt++;
    end
    key_l = 1'b0;
    key_r = 1'b0;
    repeat (4) applyStimulus("both_idle");
    chk("both pulse_count", 32'(cnt), 32'd1);

    // Left takes seven rounds and the match.
    for (int i = 0; i < WS; i++) press_round(1'b1, "left_round");
    chk("over score_l", 32'(score_l), 32'd7);
    chk("over match_over", 32'(match_over), 32'd1);
    for (int i = 0; i < 3; i++) begin
      key_l = 1'b1;
      key_r = (i != 1);
      repeat (4) applyStimulus("over_press");
      key_l = 1'b0;
      key_r = 1'b0;
      repeat (3) applyStimulus("over_idle");
    end

    // Reset in the middle of the third right win.
    do_reset("reset_over");
    repeat (2) applyStimulus("serve2");
    press_round(1'b0, "right_round");
    press_round(1'b0, "right_round");
    lights = 9'h001;
    key_r = 1'b1;
    repeat (3) applyStimulus("right3");
    key_r = 1'b0;
    repeat (2) applyStimulus("right3_hold");
    chk("win_r winner", 32'(winner), 32'd1);
    do_reset("reset_win_r");
    repeat (2) applyStimulus("serve3");

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) key_l = ~key_l;
      if ($urandom_range(0, 3) == 0) key_r = ~key_r;
      if ((c % 8) == 0) begin
        sel = $urandom_range(0, 3);
        case (sel)
          0: lights = 9'h100;
          1: lights = 9'h001;
          2: lights = 9'h010;
          default: lights = NL'($urandom);
        endcase
      end
      if (((m_phase == M_OVER) && ($urandom_range(0, 9) == 0)) ||
          ($urandom_range(0, 599) == 0)) begin
        do_reset("rand_reset");
      end
      applyStimulus("rand");
    end

    $display("%0d/%0d checks passed", npass, nchecks);
    $finish;
  end

endmodule
